braille_trainer_ctrl: RTL and testbench

Session controller for the Braille Script Trainer. It consumes single-cycle shaped button pulses (six dot keys, enter, clear, start) and requests target characters from the character source. It accumulates the user's 6-dot cell, grades it against the target, enforces an entry timeout, and holds a grading indication for a fixed feedback window. Its outputs drive the LED/7-segment display logic.

---
 rtl/trainer_pkg.sv | 21 ++
 rtl/braille_trainer_ctrl_if.sv | 33 +++
 rtl/trainer_timer.sv | 27 ++
 rtl/braille_trainer_ctrl.sv | 153 +++++++++++++++
 tb/tb_braille_trainer_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trainer_pkg.sv
// Shared types and constants for the Braille trainer session controller.
package trainer_pkg;

  localparam int unsigned DOT_W               = 6;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 250_000_000;  // 5 s at 50 MHz
  localparam int unsigned DEF_FEEDBACK_CYCLES = 50_000_000;   // 1 s at 50 MHz

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_CAP,
    ENTRY,
    CHECK,
    FEEDBACK
  } state_t;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/braille_trainer_ctrl_if.sv
// Button/character-source/display bundle of the session controller.
interface braille_trainer_ctrl_if
  import trainer_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
);

  logic               start_pulse;
  logic [DOT_W-1:0]   dot_pulse;
  logic               enter_pulse;
  logic               clear_pulse;
  logic [DOT_W-1:0]   target;
  logic               next_req;
  logic [DOT_W-1:0]   dots;
  logic [DOT_W-1:0]   target_q;
  logic               correct;
  logic               wrong;
  logic               timeout;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] attempts;
  logic               busy;

  modport master (
    output start_pulse, dot_pulse, enter_pulse, clear_pulse, target,
    input  next_req, dots, target_q, correct, wrong, timeout, score, attempts, busy
  );

  modport slave (
    input  start_pulse, dot_pulse, enter_pulse, clear_pulse, target,
    output next_req, dots, target_q, correct, wrong, timeout, score, attempts, busy
  );

endinterface

// File: rtl/trainer_timer.sv
// Loadable down-counter shared by the entry-timeout and feedback phases.
module trainer_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/braille_trainer_ctrl.sv
// Session controller: requests targets, accumulates the 6-dot cell,
// grades submissions, enforces the entry timeout and holds feedback.
module braille_trainer_ctrl
  import trainer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FEEDBACK_CYCLES = DEF_FEEDBACK_CYCLES,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  braille_trainer_ctrl_if.slave  bus
);

  localparam int unsigned MAX_CYC = max_cycles(TIMEOUT_CYCLES, FEEDBACK_CYCLES);
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0]   TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   FB_LOAD = TMR_W'(FEEDBACK_CYCLES - 1);
  localparam logic [SCORE_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [DOT_W-1:0]   dots_r;
  logic [DOT_W-1:0]   target_r;
  logic               next_req_r;
  logic               correct_r;
  logic               wrong_r;
  logic               timeout_r;
  logic               busy_r;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] attempts_r;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;

  logic entry_reload;
  assign entry_reload = bus.clear_pulse || (!bus.enter_pulse && (bus.dot_pulse != '0));

  // Timer load requests: entry window on capture and on clear/dot activity,
  // feedback window on every transition into FEEDBACK.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TO_LOAD;
    case (state)
      LOAD_CAP: tmr_load = 1'b1;
      ENTRY: begin
        if (entry_reload) begin
          tmr_load = 1'b1;
        end else if (!bus.enter_pulse && tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = FB_LOAD;
        end
      end
      CHECK: begin
        tmr_load = 1'b1;
        tmr_val  = FB_LOAD;
      end
      default: ;
    endcase
  end

  trainer_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Session state machine with registered outputs and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dots_r     <= '0;
      target_r   <= '0;
      next_req_r <= 1'b0;
      correct_r  <= 1'b0;
      wrong_r    <= 1'b0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
      score_r    <= '0;
      attempts_r <= '0;
    end else begin
      next_req_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_pulse) begin
            state      <= LOAD_REQ;
            next_req_r <= 1'b1;
            busy_r     <= 1'b1;
            score_r    <= '0;
            attempts_r <= '0;
            dots_r     <= '0;
          end
        end
        LOAD_REQ: state <= LOAD_CAP;
        LOAD_CAP: begin
          target_r <= bus.target;
          dots_r   <= '0;
          state    <= ENTRY;
        end
        ENTRY: begin
          if (bus.clear_pulse) begin
            dots_r <= '0;
          end else if (bus.enter_pulse) begin
            state <= CHECK;
          end else if (bus.dot_pulse != '0) begin
            dots_r <= dots_r ^ bus.dot_pulse;
          end else if (tmr_zero) begin
            state     <= FEEDBACK;
            timeout_r <= 1'b1;
            wrong_r   <= 1'b1;
            if (attempts_r != CNT_MAX) attempts_r <= attempts_r + SCORE_W'(1);
          end
        end
        CHECK: begin
          state <= FEEDBACK;
          if (dots_r == target_r) begin
            correct_r <= 1'b1;
            if (score_r != CNT_MAX) score_r <= score_r + SCORE_W'(1);
          end else begin
            wrong_r <= 1'b1;
          end
          if (attempts_r != CNT_MAX) attempts_r <= attempts_r + SCORE_W'(1);
        end
        FEEDBACK: begin
          if (tmr_zero) begin
            state      <= LOAD_REQ;
            next_req_r <= 1'b1;
            correct_r  <= 1'b0;
            wrong_r    <= 1'b0;
            timeout_r  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.next_req = next_req_r;
  assign bus.dots     = dots_r;
  assign bus.target_q = target_r;
  assign bus.correct  = correct_r;
  assign bus.wrong    = wrong_r;
  assign bus.timeout  = timeout_r;
  assign bus.score    = score_r;
  assign bus.attempts = attempts_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_braille_trainer_ctrl.sv
// Randomized self-checking bench for braille_trainer_ctrl. Two instances
// (8-bit and 2-bit counters) share one stimulus stream.
module tb_braille_trainer_ctrl;

  localparam int unsigned T = 20;
  localparam int unsigned F = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  braille_trainer_ctrl_if #(.SCORE_W(8)) bus8 ();
  braille_trainer_ctrl_if #(.SCORE_W(2)) bus2 ();

  assign bus2.start_pulse = bus8.start_pulse;
  assign bus2.dot_pulse   = bus8.dot_pulse;
  assign bus2.enter_pulse = bus8.enter_pulse;
  assign bus2.clear_pulse = bus8.clear_pulse;
  assign bus2.target      = bus8.target;

  braille_trainer_ctrl #(.TIMEOUT_CYCLES(T), .FEEDBACK_CYCLES(F), .SCORE_W(8)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8.slave)
  );
  braille_trainer_ctrl #(.TIMEOUT_CYCLES(T), .FEEDBACK_CYCLES(F), .SCORE_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: session-level counts and the user's cell.
  int unsigned score_cnt;
  int unsigned att_cnt;
  int unsigned idle_since;  // idle ENTRY cycles since the last timer reload
  logic [5:0]  tgt;
  logic [5:0]  exp_dots;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x, input int unsigned w);
    int unsigned m;
    m = (1 << w) - 1;
    return (x > m) ? m : x;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus8.start_pulse = 1'b0;
    bus8.dot_pulse   = '0;
    bus8.enter_pulse = 1'b0;
    bus8.clear_pulse = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    check_eq({tag, "_score8"}, 32'(bus8.score),    sat(score_cnt, 8));
    check_eq({tag, "_att8"},   32'(bus8.attempts), sat(att_cnt, 8));
    check_eq({tag, "_score2"}, 32'(bus2.score),    sat(score_cnt, 2));
    check_eq({tag, "_att2"},   32'(bus2.attempts), sat(att_cnt, 2));
  endtask

  task automatic chk_all_zero(input string tag);
    check_eq({tag, "_dots"},     32'(bus8.dots),     0);
    check_eq({tag, "_target_q"}, 32'(bus8.target_q), 0);
    check_eq({tag, "_next_req"}, 32'(bus8.next_req), 0);
    check_eq({tag, "_correct"},  32'(bus8.correct),  0);
    check_eq({tag, "_wrong"},    32'(bus8.wrong),    0);
    check_eq({tag, "_timeout"},  32'(bus8.timeout),  0);
    check_eq({tag, "_busy"},     32'(bus8.busy),     0);
    check_eq({tag, "_correct2"}, 32'(bus2.correct),  0);
    check_eq({tag, "_busy2"},    32'(bus2.busy),     0);
    chk_cnt(tag);
  endtask

  task automatic start_session();
    bus8.start_pulse = 1'b1;
    tick();
    bus8.start_pulse = 1'b0;
    score_cnt = 0;
    att_cnt   = 0;
    check_eq("start_busy", 32'(bus8.busy), 1);
  endtask

  // Called on the cycle next_req is high; leaves the bench on the first ENTRY cycle.
  task automatic begin_round(input logic [5:0] t);
    check_eq("next_req", 32'(bus8.next_req), 1);
    tgt = t;
    bus8.target = ~t;
    tick();
    check_eq("next_req_1cyc", 32'(bus8.next_req), 0);
    bus8.target = t;
    tick();
    bus8.target = 6'($urandom);
    check_eq("target_q8", 32'(bus8.target_q), 32'(t));
    check_eq("target_q2", 32'(bus2.target_q), 32'(t));
    check_eq("entry_dots", 32'(bus8.dots), 0);
    check_eq("entry_fb", 32'(bus8.correct | bus8.wrong), 0);
    exp_dots   = '0;
    idle_since = 0;
  endtask

  // Non-submitting ENTRY action: clear (optionally with enter/dots) or a dot toggle.
  task automatic pulse(input logic clr, input logic ent, input logic [5:0] m);
    bus8.clear_pulse = clr;
    bus8.enter_pulse = ent & clr;
    bus8.dot_pulse   = m;
    tick();
    clr_inputs();
    if (clr) begin
      exp_dots   = '0;
      idle_since = 0;
    end else if (m != '0) begin
      exp_dots   = exp_dots ^ m;
      idle_since = 0;
    end else begin
      idle_since++;
    end
    check_eq("pulse_dots", 32'(bus8.dots), 32'(exp_dots));
    check_eq("pulse_in_entry", 32'(bus8.correct | bus8.wrong), 0);
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      bus8.start_pulse = 1'($urandom_range(0, 1));
      tick();
      idle_since++;
    end
    clr_inputs();
    check_eq("idle_dots", 32'(bus8.dots), 32'(exp_dots));
    check_eq("idle_in_entry", 32'(bus8.wrong), 0);
  endtask

  task automatic feedback_window(input logic ec, input logic ew, input logic eto);
    int unsigned n;
    n = 0;
    check_eq("fb_enter_correct", 32'(bus8.correct), 32'(ec));
    check_eq("fb_enter_wrong",   32'(bus8.wrong),   32'(ew));
    check_eq("fb_enter_timeout", 32'(bus8.timeout), 32'(eto));
    check_eq("fb_enter_correct2", 32'(bus2.correct), 32'(ec));
    chk_cnt("fb_enter");
    while ((bus8.correct || bus8.wrong) && n < F + 4) begin
      check_eq("fb_correct", 32'(bus8.correct), 32'(ec));
      check_eq("fb_wrong",   32'(bus8.wrong),   32'(ew));
      check_eq("fb_timeout", 32'(bus8.timeout), 32'(eto));
      check_eq("fb_dots",    32'(bus8.dots),    32'(exp_dots));
      bus8.dot_pulse   = 6'($urandom);
      bus8.clear_pulse = 1'($urandom_range(0, 1));
      bus8.enter_pulse = 1'($urandom_range(0, 1));
      bus8.start_pulse = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    clr_inputs();
    check_eq("fb_len", n, F);
    check_eq("fb_next_req", 32'(bus8.next_req), 1);
    check_eq("fb_dots_held", 32'(bus8.dots), 32'(exp_dots));
    chk_cnt("fb_exit");
  endtask

  task automatic submit(input logic [5:0] m);
    logic ok;
    bus8.enter_pulse = 1'b1;
    bus8.dot_pulse   = m;
    tick();
    clr_inputs();
    check_eq("check_dots", 32'(bus8.dots), 32'(exp_dots));
    check_eq("check_no_fb", 32'(bus8.correct | bus8.wrong), 0);
    tick();
    ok = (exp_dots == tgt);
    att_cnt++;
    if (ok) score_cnt++;
    feedback_window(ok, !ok, 1'b0);
  endtask

  task automatic let_timeout();
    int unsigned n;
    n = idle_since;
    while (!bus8.wrong && n < T + 4) begin
      tick();
      n++;
    end
    check_eq("to_len", n, T);
    att_cnt++;
    feedback_window(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] t;
    rst = 1'b0;
    clr_inputs();
    bus8.target = '0;
    score_cnt = 0;
    att_cnt   = 0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();
    bus8.dot_pulse   = 6'h3f;
    bus8.enter_pulse = 1'b1;
    bus8.clear_pulse = 1'b1;
    tick();
    clr_inputs();
    chk_all_zero("idle_ignore");

    // Correct entry
    start_session();
    begin_round(6'b000101);
    pulse(1'b0, 1'b0, 6'b000001);
    pulse(1'b0, 1'b0, 6'b000100);
    submit(6'b000000);

    // Toggle-off and wrong entry
    begin_round(6'b000011);
    pulse(1'b0, 1'b0, 6'b000001);
    pulse(1'b0, 1'b0, 6'b000001);
    pulse(1'b0, 1'b0, 6'b000010);
    submit(6'b000000);

    // Timeout
    begin_round(6'($urandom));
    idle(3);
    let_timeout();

    // Simultaneous pulses
    begin_round(6'b101101);
    pulse(1'b0, 1'b0, 6'h3f);
    pulse(1'b1, 1'b1, 6'h00);
    idle(2);
    pulse(1'b0, 1'b0, 6'h0a);
    pulse(1'b1, 1'b0, 6'h15);
    pulse(1'b0, 1'b0, 6'b101101);
    submit(6'b000001);

    // Enter on the last timer cycle wins; empty cell vs empty target is correct
    begin_round(6'b000000);
    idle(T - 1);
    submit(6'b000000);

    // Reload at timer zero extends the window
    begin_round(6'($urandom));
    idle(T - 1);
    pulse(1'b0, 1'b0, 6'b010000);
    idle(T - 1);
    pulse(1'b1, 1'b0, 6'b000000);
    let_timeout();

    // Random rounds
    for (int r = 0; r < 14; r++) begin
      begin_round(6'($urandom));
      for (int a = 0; a < int'($urandom_range(0, 5)); a++) begin
        case ($urandom_range(0, 2))
          0: pulse(1'b0, 1'b0, 6'($urandom_range(1, 63)));
          1: pulse(1'b1, 1'($urandom_range(0, 1)), 6'($urandom));
          default: idle($urandom_range(0, T - 1 - idle_since));
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        let_timeout();
      end else begin
        if ($urandom_range(0, 1) == 1 && (exp_dots ^ tgt) != '0)
          pulse(1'b0, 1'b0, exp_dots ^ tgt);
        submit(6'($urandom));
      end
    end

    // Asynchronous reset in the middle of a feedback window
    t = 6'b110010;
    begin_round(t);
    pulse(1'b0, 1'b0, t);
    bus8.enter_pulse = 1'b1;
    tick();
    clr_inputs();
    tick();
    tick();
    check_eq("pre_rst_correct8", 32'(bus8.correct), 1);
    check_eq("pre_rst_correct2", 32'(bus2.correct), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    score_cnt = 0;
    att_cnt   = 0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("post_rst");
    start_session();
    begin_round(6'b011001);
    pulse(1'b0, 1'b0, 6'b011001);
    submit(6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
